// File: rtl/status_flags.sv
// Processor status register (N,V,D,I,Z,C) with ALU/bus update ops, delayed IRQ
// mask, edge-detected NMI latch and branch condition evaluation.
module status_flags (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       alu_n,
    input  logic       alu_v,
    input  logic       alu_z,
    input  logic       alu_c,
    input  logic [2:0] flag_op,
    input  logic [2:0] bit_sel,
    input  logic       bit_val,
    input  logic [7:0] data_in,
    input  logic       rti,
    input  logic       push_brk,
    input  logic       poll,
    input  logic       nmi_n,
    input  logic       nmi_ack,
    input  logic [1:0] br_sel,
    input  logic       br_val,
    output logic [7:0] p_push,
    output logic       carry_out,
    output logic       overflow_out,
    output logic       irq_mask,
    output logic       nmi_pending,
    output logic       br_taken
);

    localparam logic [2:0] OP_HOLD = 3'd0;
    localparam logic [2:0] OP_NZ   = 3'd1;
    localparam logic [2:0] OP_NZC  = 3'd2;
    localparam logic [2:0] OP_NZCV = 3'd3;
    localparam logic [2:0] OP_BIT  = 3'd4;
    localparam logic [2:0] OP_LOAD = 3'd5;
    localparam logic [2:0] OP_INT  = 3'd6;
    localparam logic [2:0] OP_SETC = 3'd7;

    logic r_n, r_v, r_d, r_i, r_z, r_c;
    logic r_irq_mask;
    logic r_nmi_s1, r_nmi_s2, r_nmi_prev, r_nmi_pending;

    logic w_n_nxt, w_v_nxt, w_d_nxt, w_i_nxt, w_z_nxt, w_c_nxt;
    logic w_nmi_fall;
    logic w_rti_load;
    logic w_unused;

    // data_in[5:4] (B and the constant bit) are never loaded into P
    assign w_unused = ^data_in[5:4];

    always_comb begin
        w_n_nxt = r_n;
        w_v_nxt = r_v;
        w_d_nxt = r_d;
        w_i_nxt = r_i;
        w_z_nxt = r_z;
        w_c_nxt = r_c;
        case (flag_op)
            OP_HOLD: ;
            OP_NZ: begin
                w_n_nxt = alu_n;
                w_z_nxt = alu_z;
            end
            OP_NZC: begin
                w_n_nxt = alu_n;
                w_z_nxt = alu_z;
                w_c_nxt = alu_c;
            end
            OP_NZCV: begin
                w_n_nxt = alu_n;
                w_z_nxt = alu_z;
                w_c_nxt = alu_c;
                w_v_nxt = alu_v;
            end
            OP_BIT: begin
                w_n_nxt = data_in[7];
                w_v_nxt = data_in[6];
                w_z_nxt = alu_z;
            end
            OP_LOAD: begin
                w_n_nxt = data_in[7];
                w_v_nxt = data_in[6];
                w_d_nxt = data_in[3];
                w_i_nxt = data_in[2];
                w_z_nxt = data_in[1];
                w_c_nxt = data_in[0];
            end
            OP_INT: w_i_nxt = 1'b1;
            OP_SETC: begin
                case (bit_sel)
                    3'd0:    w_c_nxt = bit_val;
                    3'd1:    w_z_nxt = bit_val;
                    3'd2:    w_i_nxt = bit_val;
                    3'd3:    w_d_nxt = bit_val;
                    3'd6:    w_v_nxt = bit_val;
                    3'd7:    w_n_nxt = bit_val;
                    default: ;
                endcase
            end
            default: ;
        endcase
    end

    assign w_rti_load = (flag_op == OP_LOAD) && rti;
    assign w_nmi_fall = r_nmi_prev & ~r_nmi_s2;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_n <= 1'b0;
            r_v <= 1'b0;
            r_d <= 1'b0;
            r_i <= 1'b1;
            r_z <= 1'b0;
            r_c <= 1'b0;
        end else begin
            r_n <= w_n_nxt;
            r_v <= w_v_nxt;
            r_d <= w_d_nxt;
            r_i <= w_i_nxt;
            r_z <= w_z_nxt;
            r_c <= w_c_nxt;
        end
    end

    // Poll samples the pre-update I, so mask changes lag one instruction
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_irq_mask <= 1'b1;
        end else if (w_rti_load) begin
            r_irq_mask <= data_in[2];
        end else if (poll) begin
            r_irq_mask <= r_i;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_nmi_s1      <= 1'b1;
            r_nmi_s2      <= 1'b1;
            r_nmi_prev    <= 1'b1;
            r_nmi_pending <= 1'b0;
        end else begin
            r_nmi_s1   <= nmi_n;
            r_nmi_s2   <= r_nmi_s1;
            r_nmi_prev <= r_nmi_s2;
            if (w_nmi_fall) begin
                r_nmi_pending <= 1'b1;
            end else if (nmi_ack) begin
                r_nmi_pending <= 1'b0;
            end
        end
    end

    assign p_push       = {r_n, r_v, 1'b1, push_brk, r_d, r_i, r_z, r_c};
    assign carry_out    = r_c;
    assign overflow_out = r_v;
    assign irq_mask     = r_irq_mask;
    assign nmi_pending  = r_nmi_pending;

    always_comb begin
        case (br_sel)
            2'd0:    br_taken = (r_n == br_val);
            2'd1:    br_taken = (r_v == br_val);
            2'd2:    br_taken = (r_c == br_val);
            default: br_taken = (r_z == br_val);
        endcase
    end

endmodule
